// File: rtl/replay_pkg.sv
// Shared definitions for the replay buffer controller.
//   state_e          : controller FSM states (idle, purge acked entries, replay)
//   SEQ_W / SEQ_HALF : 12-bit sequence number width and half of its range
//   seq_at_or_before : modulo-4096 ordering of two sequence numbers
package replay_pkg;

   localparam int unsigned SEQ_W = 12;
   localparam logic [SEQ_W-1:0] SEQ_HALF = 12'd2048;

   typedef enum logic [1:0] {
      StIdle,
      StPurge,
      StReplay
   } state_e;

   // a is at-or-before b when b lies in the half-range at or ahead of a.
   function automatic logic seq_at_or_before(input logic [SEQ_W-1:0] a,
                                             input logic [SEQ_W-1:0] b);
      logic [SEQ_W-1:0] diff;
      diff = b - a;
      return diff < SEQ_HALF;
   endfunction

endpackage

// File: rtl/replay_ram.sv
// Simple dual-port storage for the replay buffer.
//   clk, rst            : clock and asynchronous active-low reset (read register only)
//   wr_en_i/addr/data   : write port
//   rd_en_i/rd_addr_i   : read request; rd_data_o is valid the cycle after and holds
//                         its value while rd_en_i is low
module replay_ram #(
   parameter int unsigned WIDTH = 28,
   parameter int unsigned DEPTH = 64,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   input  logic [AW-1:0]    rd_addr_i,
   output logic [WIDTH-1:0] rd_data_o
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem[wr_addr_i] <= wr_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= mem[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/replay_buffer_ctrl.sv
// Replay buffer controller: stores transmitted TLP words tagged with a 12-bit
// sequence number, purges them on ACK/NAK and replays the remainder on NAK or
// replay-timer expiry.
//   clk, rst                     : clock, asynchronous active-low reset
//   wr_valid/wr_data/wr_ready    : TLP store handshake
//   ack_valid/nak_valid/dllp_seq : ACK/NAK DLLP with its sequence number
//   tim_out                      : replay-timer expiry pulse
//   rp_valid/rp_ready/rp_data/rp_seq : replay stream
//   next_seq/count/empty/full    : buffer status
//   replay_num/retrain_req       : replay counter and link-retrain pulse
module replay_buffer_ctrl
   import replay_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_valid,
   input  logic [DATA_W-1:0]         wr_data,
   output logic                      wr_ready,
   input  logic                      ack_valid,
   input  logic                      nak_valid,
   input  logic [SEQ_W-1:0]          dllp_seq,
   input  logic                      tim_out,
   output logic                      rp_valid,
   input  logic                      rp_ready,
   output logic [DATA_W-1:0]         rp_data,
   output logic [SEQ_W-1:0]          rp_seq,
   output logic [SEQ_W-1:0]          next_seq,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      empty,
   output logic                      full,
   output logic [1:0]                replay_num,
   output logic                      retrain_req
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   state_e           state_q, state_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    head_ptr_q, head_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [SEQ_W-1:0] next_seq_q, next_seq_d;
   logic [SEQ_W-1:0] lat_seq_q, lat_seq_d;
   logic             is_nak_q, is_nak_d;
   logic [1:0]       replay_num_q, replay_num_d;
   logic             retrain_q, retrain_d;
   logic             rp_valid_q, rp_valid_d;

   logic                    wr_fire, rd_en, enter_replay;
   logic                    purge_hit, purge_more, remain_nonempty;
   logic [SEQ_W-1:0]        head_seq;
   logic [DATA_W+SEQ_W-1:0] rd_word;

   assign count = wr_ptr_q - head_ptr_q;
   assign empty = (count == '0);
   assign full  = (count == PW'(DEPTH));

   // Stored sequence numbers are contiguous, so the head tag follows from
   // next_seq and the fill level without a RAM lookup.
   assign head_seq = next_seq_q - SEQ_W'(count);

   // Gated by rst so the store port is closed during reset and opens as soon
   // as reset is released.
   assign wr_ready = rst && (state_q == StIdle) && !full &&
                     !ack_valid && !nak_valid && !tim_out;
   assign wr_fire  = wr_valid && wr_ready;

   assign purge_hit  = !empty && seq_at_or_before(head_seq, lat_seq_q);
   // Whether the entry behind the one being removed also qualifies.
   assign purge_more = (count > PW'(1)) && seq_at_or_before(head_seq + 12'd1, lat_seq_q);

   always_comb begin
      state_d         = state_q;
      wr_ptr_d        = wr_ptr_q;
      head_ptr_d      = head_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      next_seq_d      = next_seq_q;
      lat_seq_d       = lat_seq_q;
      is_nak_d        = is_nak_q;
      replay_num_d    = replay_num_q;
      retrain_d       = 1'b0;
      rp_valid_d      = rp_valid_q;
      rd_en           = 1'b0;
      enter_replay    = 1'b0;
      remain_nonempty = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (nak_valid || ack_valid) begin
               lat_seq_d = dllp_seq;
               is_nak_d  = nak_valid;
               state_d   = StPurge;
            end else if (tim_out && !empty) begin
               enter_replay = 1'b1;
            end else if (wr_fire) begin
               wr_ptr_d   = wr_ptr_q + PW'(1);
               next_seq_d = next_seq_q + 12'd1;
            end
         end
         StPurge: begin
            if (purge_hit) begin
               head_ptr_d   = head_ptr_q + PW'(1);
               replay_num_d = 2'd0;
            end
            // Leave in the same cycle as the last removal.
            if (!purge_hit || !purge_more) begin
               remain_nonempty = purge_hit ? (count > PW'(1)) : !empty;
               if (is_nak_q && remain_nonempty) begin
                  enter_replay = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StReplay: begin
            if ((rd_ptr_q != wr_ptr_q) && (!rp_valid_q || rp_ready)) begin
               rd_en      = 1'b1;
               rd_ptr_d   = rd_ptr_q + PW'(1);
               rp_valid_d = 1'b1;
            end else if (rp_valid_q && rp_ready) begin
               // Last entry handed over; nothing left to read.
               rp_valid_d = 1'b0;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (enter_replay) begin
         state_d    = StReplay;
         rd_ptr_d   = head_ptr_d;
         rp_valid_d = 1'b0;
         if (replay_num_d == 2'd3) begin
            retrain_d    = 1'b1;
            replay_num_d = 2'd0;
         end else begin
            replay_num_d = replay_num_d + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         wr_ptr_q     <= '0;
         head_ptr_q   <= '0;
         rd_ptr_q     <= '0;
         next_seq_q   <= '0;
         lat_seq_q    <= '0;
         is_nak_q     <= 1'b0;
         replay_num_q <= '0;
         retrain_q    <= 1'b0;
         rp_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         head_ptr_q   <= head_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         next_seq_q   <= next_seq_d;
         lat_seq_q    <= lat_seq_d;
         is_nak_q     <= is_nak_d;
         replay_num_q <= replay_num_d;
         retrain_q    <= retrain_d;
         rp_valid_q   <= rp_valid_d;
      end
   end

   replay_ram #(
      .WIDTH (DATA_W + SEQ_W),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (wr_fire),
      .wr_addr_i (wr_ptr_q[AW-1:0]),
      .wr_data_i ({next_seq_q, wr_data}),
      .rd_en_i   (rd_en),
      .rd_addr_i (rd_ptr_q[AW-1:0]),
      .rd_data_o (rd_word)
   );

   assign rp_data     = rd_word[DATA_W-1:0];
   assign rp_seq      = rd_word[DATA_W +: SEQ_W];
   assign rp_valid    = rp_valid_q;
   assign next_seq    = next_seq_q;
   assign replay_num  = replay_num_q;
   assign retrain_req = retrain_q;

endmodule

// File: tb/tb_replay_buffer_ctrl.sv
// Directed bench for replay_buffer_ctrl with a small reference model of the
// stored entries and a scoreboard of expected replay words.
module tb_replay_buffer_ctrl;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              wr_valid = 1'b0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              wr_ready;
   logic              ack_valid = 1'b0;
   logic              nak_valid = 1'b0;
   logic [11:0]       dllp_seq = '0;
   logic              tim_out = 1'b0;
   logic              rp_valid;
   logic              rp_ready = 1'b1;
   logic [DATA_W-1:0] rp_data;
   logic [11:0]       rp_seq;
   logic [11:0]       next_seq;
   logic [3:0]        count;
   logic              empty, full;
   logic [1:0]        replay_num;
   logic              retrain_req;

   replay_buffer_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .ack_valid(ack_valid), .nak_valid(nak_valid), .dllp_seq(dllp_seq),
      .tim_out(tim_out),
      .rp_valid(rp_valid), .rp_ready(rp_ready), .rp_data(rp_data), .rp_seq(rp_seq),
      .next_seq(next_seq), .count(count), .empty(empty), .full(full),
      .replay_num(replay_num), .retrain_req(retrain_req)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [11:0] seq;
      logic [15:0] data;
   } ent_t;

   ent_t        model_q[$];
   ent_t        exp_q[$];
   logic [11:0] m_seq = '0;
   logic [1:0]  m_rn = '0;
   int          n_chk = 0;
   int          n_fail = 0;
   int          rt_cnt = 0;

   always @(negedge clk) if (retrain_req === 1'b1) rt_cnt++;

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: observed no finish, required finish");
      $fatal(1, "global timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit older_eq(input logic [11:0] a, input logic [11:0] b);
      logic [11:0] d;
      d = b - a;
      return d < 12'd2048;
   endfunction

   task automatic model_purge(input logic [11:0] s, output bit removed);
      removed = 1'b0;
      while (model_q.size() > 0 && older_eq(model_q[0].seq, s)) begin
         void'(model_q.pop_front());
         removed = 1'b1;
      end
   endtask

   // Model update for a replay: bump the counter and queue every stored entry.
   task automatic model_replay(output bit exp_rt);
      exp_rt = 1'b0;
      if (m_rn == 2'd3) begin
         m_rn   = 2'd0;
         exp_rt = 1'b1;
      end else begin
         m_rn = m_rn + 2'd1;
      end
      foreach (model_q[i]) exp_q.push_back(model_q[i]);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      wr_valid = 0; ack_valid = 0; nak_valid = 0; tim_out = 0; rp_ready = 1;
      #1;
      model_q.delete();
      exp_q.delete();
      m_seq = '0;
      m_rn  = '0;
      step();
      rst = 1'b1;
      #1;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (!wr_ready && t < 100) begin
         step();
         t++;
      end
      if (t == 100) chk("idle_timeout", wr_ready, 1);
   endtask

   task automatic do_write(input logic [15:0] d);
      int t = 0;
      wr_valid = 1'b1;
      wr_data  = d;
      while (!wr_ready && t < 50) begin
         step();
         t++;
      end
      if (t == 50) begin
         chk("wr_ready_timeout", wr_ready, 1);
      end else begin
         step();
         model_q.push_back('{seq: m_seq, data: d});
         m_seq = m_seq + 12'd1;
      end
      wr_valid = 1'b0;
   endtask

   task automatic replay_collect(input int stall_idx);
      int   got = 0;
      int   cyc = 0;
      int   stall = 0;
      ent_t e;
      rp_ready = 1'b1;
      while (exp_q.size() > 0 && cyc < 300) begin
         if (got == stall_idx && rp_valid && stall < 3) begin
            rp_ready = 1'b0;
            stall++;
            chk("rp_hold_seq", rp_seq, exp_q[0].seq);
            chk("rp_hold_data", rp_data, exp_q[0].data);
         end else begin
            rp_ready = 1'b1;
            if (rp_valid) begin
               e = exp_q.pop_front();
               chk("rp_seq", rp_seq, e.seq);
               chk("rp_data", rp_data, e.data);
               got++;
            end
         end
         step();
         cyc++;
      end
      rp_ready = 1'b1;
      if (exp_q.size() != 0) begin
         chk("replay_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
      chk("rp_valid_after", rp_valid, 0);
   endtask

   task automatic do_ack(input logic [11:0] s);
      bit rm;
      ack_valid = 1'b1;
      dllp_seq  = s;
      step();
      ack_valid = 1'b0;
      model_purge(s, rm);
      if (rm) m_rn = 2'd0;
      wait_idle();
      chk("ack_count", count, model_q.size());
   endtask

   task automatic do_nak(input logic [11:0] s, input int stall_idx);
      bit rm, rt;
      nak_valid = 1'b1;
      dllp_seq  = s;
      step();
      nak_valid = 1'b0;
      model_purge(s, rm);
      if (rm) m_rn = 2'd0;
      if (model_q.size() > 0) model_replay(rt);
      replay_collect(stall_idx);
      wait_idle();
      chk("nak_count", count, model_q.size());
      chk("nak_replay_num", replay_num, m_rn);
   endtask

   task automatic do_tim(input int stall_idx);
      bit rt = 1'b0;
      tim_out = 1'b1;
      step();
      tim_out = 1'b0;
      if (model_q.size() > 0) model_replay(rt);
      chk("tim_replay_num", replay_num, m_rn);
      chk("tim_retrain", retrain_req, rt);
      replay_collect(stall_idx);
      wait_idle();
   endtask

   initial begin
      bit rm;
      // Reset state
      #1 rst = 1'b0;
      step();
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_rp_valid", rp_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_next_seq", next_seq, 0);
      chk("rst_replay_num", replay_num, 0);
      chk("rst_retrain", retrain_req, 0);
      chk("rst_rp_data", rp_data, 0);
      chk("rst_rp_seq", rp_seq, 0);
      rst = 1'b1;
      #1;
      chk("wr_ready_after_rst", wr_ready, 1);

      // Five writes, tags 0..4 via a timer replay
      for (int i = 0; i < 5; i++) do_write(16'hA000 + 16'(i));
      chk("w5_count", count, 5);
      chk("w5_next_seq", next_seq, 5);
      do_tim(-1);

      // ACK seq=2: three purge cycles, then idle
      ack_valid = 1'b1;
      dllp_seq  = 12'd2;
      step();
      ack_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("purge_busy", wr_ready, 0);
         step();
      end
      model_purge(12'd2, rm);
      if (rm) m_rn = 2'd0;
      chk("ack2_count", count, model_q.size());
      chk("ack2_idle", wr_ready, 1);
      chk("ack2_replay_num", replay_num, m_rn);

      // NAK seq=1 after five writes
      do_reset();
      for (int i = 0; i < 5; i++) do_write(16'(16'hB100 + 16'(i * 3)));
      do_nak(12'd1, -1);

      // Four timer replays of two entries
      do_reset();
      do_write(16'h1111);
      do_write(16'h2222);
      rt_cnt = 0;
      for (int i = 0; i < 4; i++) do_tim(-1);
      chk("retrain_pulses", rt_cnt, 1);
      chk("rt4_count", count, 2);

      // Fill to DEPTH, then ACK everything
      do_reset();
      for (int i = 0; i < DEPTH; i++) do_write(16'($urandom_range(0, 65535)));
      chk("full_flag", full, 1);
      chk("full_wr_ready", wr_ready, 0);
      do_ack(12'(DEPTH - 1));
      chk("empty_after_ack", empty, 1);

      // Advance the sequence number close to the wrap point
      while (m_seq != 12'd4093) begin
         while (model_q.size() < DEPTH && m_seq != 12'd4093)
            do_write(16'($urandom_range(0, 65535)));
         do_ack(m_seq - 12'd1);
      end
      for (int i = 0; i < 6; i++) do_write(16'($urandom_range(0, 65535)));
      chk("wrap_next_seq", next_seq, 3);
      do_ack(12'd4095);
      chk("wrap_count", count, 3);
      do_tim(-1);
      // Stale NAK replays everything; stale ACK changes nothing
      do_nak(12'd4000, -1);
      do_ack(12'd4000);
      chk("stale_ack_count", count, 3);

      // Back-pressure mid-replay
      do_reset();
      for (int i = 0; i < 5; i++) do_write(16'(16'hC000 + 16'(i)));
      do_tim(2);

      // Reset mid-replay
      tim_out = 1'b1;
      step();
      tim_out = 1'b0;
      step();
      step();
      step();
      chk("mid_replay_valid", rp_valid, 1);
      rst = 1'b0;
      #1;
      chk("rst_mid_rp_valid", rp_valid, 0);
      chk("rst_mid_count", count, 0);
      chk("rst_mid_replay_num", replay_num, 0);
      step();
      rst = 1'b1;
      #1;
      chk("post_rst_wr_ready", wr_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/replay_buffer_ctrl.md
REPLAY_BUFFER_CTRL -- requirements
Module: replay_buffer_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, the width of one stored TLP word.
REQ-002 SHALL have parameter DEPTH, default 64, the entry count; power of 2, range 4..2048.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports wr_valid (in, 1), wr_data (in, DATA_W) and wr_ready (out, 1) for the TLP store handshake.
REQ-006 SHALL have ports ack_valid (in, 1), nak_valid (in, 1) and dllp_seq (in, 12) for the ACK/NAK DLLP with its sequence number.
REQ-007 SHALL have port tim_out, input, 1 bit: single-cycle replay-timer expiry pulse.
REQ-008 SHALL have ports rp_valid (out, 1), rp_ready (in, 1), rp_data (out, DATA_W) and rp_seq (out, 12) for the replay stream.
REQ-009 SHALL have ports next_seq (out, 12), count (out, log2(DEPTH)+1), empty (out, 1) and full (out, 1).
REQ-010 SHALL have ports replay_num (out, 2) and retrain_req (out, 1): the replay counter and a one-cycle link-retrain request.

Function
REQ-011 SHALL store one TLP per entry, tagged with next_seq on a wr_valid&&wr_ready cycle; next_seq then increments mod 4096.
REQ-012 SHALL drive wr_ready=1 only in IDLE, with !full, and with no ack_valid/nak_valid/tim_out in that cycle.
REQ-013 SHALL compare sequence numbers mod 4096: a is at-or-before b iff (b-a) mod 4096 < 2048.
REQ-014 SHALL use FSM states IDLE, PURGE and REPLAY.
REQ-015 SHALL, on IDLE with ack_valid or nak_valid, latch dllp_seq and enter PURGE.
REQ-016 SHALL, in PURGE, remove one head entry per cycle while the head seq is at-or-before the latched seq.
REQ-017 SHALL, when PURGE stops (head after the latched seq, or empty), go to IDLE for ACK, or to REPLAY for NAK if non-empty.
REQ-018 SHALL reset replay_num to 0 when a PURGE removes at least one entry.
REQ-019 SHALL, on IDLE with tim_out and non-empty, enter REPLAY directly; tim_out while empty SHALL be ignored.
REQ-020 SHALL give priority nak_valid > ack_valid > tim_out > write when they coincide; ack_valid/nak_valid/tim_out outside IDLE SHALL be dropped.
REQ-021 SHALL increment replay_num on REPLAY entry; on entry with replay_num==3 it SHALL pulse retrain_req for one cycle, set replay_num to 0, and still replay.
REQ-022 SHALL, in REPLAY, stream every stored entry in order from head to tail without removing any.
REQ-023 SHALL assert rp_valid no earlier than 1 cycle after REPLAY entry (synchronous RAM read).
REQ-024 SHALL hold rp_data/rp_seq stable while rp_valid&&!rp_ready, advancing only on handshake.
REQ-025 SHALL return to IDLE the cycle after the last entry's handshake; rp_valid SHALL be 0 outside REPLAY.
REQ-026 SHALL compute count as write pointer minus head pointer, with pointers log2(DEPTH)+1 bits wide and wrapping naturally.
REQ-027 SHALL assert full when count==DEPTH and empty when count==0, combinationally from registers.
REQ-028 SHALL leave NAK with a dllp_seq older than the head to purge nothing and replay everything; ACK in that case SHALL be a no-op.

Reset
REQ-029 SHALL, on rst low, immediately set state=IDLE, pointers=0, next_seq=0, replay_num=0, retrain_req=0, rp_valid=0, rp_data=0, rp_seq=0 and wr_ready=0.
REQ-030 SHALL, on reset assertion mid-PURGE or mid-REPLAY, abandon the operation; RAM contents need not be cleared.
REQ-031 SHALL allow wr_ready to rise in the first cycle after rst deasserts.

Structure
REQ-032 SHALL place the FSM state enum, SEQ_W=12 and SEQ_HALF=2048 in shared package replay_pkg.
REQ-033 SHALL instantiate sub-module replay_ram: 1 write port, 1 synchronous read port, DATA_W+12 bits wide, DEPTH entries.

Verification
REQ-034 SHALL cover 5 writes after reset: rp_seq tags 0..4, count=5, next_seq=5.
REQ-035 SHALL cover 5 writes then ACK seq=2: 3 cycles of PURGE, count=2, replay_num=0, IDLE.
REQ-036 SHALL cover 5 writes then NAK seq=1: count=3, replay of seqs 2,3,4 in order, replay_num=1.
REQ-037 SHALL cover 4 consecutive tim_out replays of 2 entries: replay_num 1,2,3; 4th replay pulses retrain_req once, replay_num=0, both entries replayed.
REQ-038 SHALL cover DEPTH writes: full=1 and wr_ready=0; then ACK of all: empty=1; a wrap test with next_seq crossing 4095->0 and ACK seq=4095 purges only entries <=4095.
REQ-039 SHALL cover rp_ready held low 3 cycles mid-replay (rp_data stable), and rst low mid-REPLAY (rp_valid=0 at once, count=0).
